// File: rtl/word_packer.sv
// Packs an 8-bit byte stream into 32-bit words with a byte strobe and last flag.
// One partial word is assembled while one finished word waits in the output register.
module word_packer #(
  parameter bit BigEndian = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  in_data_i,
  input  logic        in_last_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [31:0] out_data_o,
  output logic [3:0]  out_strb_o,
  output logic        out_last_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [1:0]  fill_o
);

  localparam int unsigned ByteW    = 8;
  localparam int unsigned NumLanes = 4;
  localparam int unsigned WordW    = ByteW * NumLanes;
  localparam int unsigned AsmW     = ByteW * (NumLanes - 1);
  localparam int unsigned CntW     = 2;

  typedef logic [WordW-1:0] word_t;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AsmW-1:0]     asm_q, asm_d;
  word_t               data_q, data_d;
  logic [NumLanes-1:0] strb_q, strb_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;

  logic                accept_c;
  logic                emit_byte_c;
  logic                flush_fire_c;
  logic                load_c;
  logic [CntW:0]       nbytes_c;
  word_t               asm_wide_c;
  word_t               word_le_c;
  logic [NumLanes-1:0] strb_le_c;
  word_t               word_out_c;
  logic [NumLanes-1:0] strb_out_c;

  // Ready only drops while a finished word is held and not being taken.
  assign in_ready_o = !valid_q || out_ready_i;

  // Accept/emit decisions and the little-endian view of the word being emitted.
  always_comb begin
    accept_c     = in_valid_i && in_ready_o;
    emit_byte_c  = accept_c && ((cnt_q == CntW'(NumLanes - 1)) || in_last_i || flush_i);
    flush_fire_c = flush_i && in_ready_o && !accept_c && (cnt_q != '0);
    load_c       = emit_byte_c || flush_fire_c;
    nbytes_c     = {1'b0, cnt_q} + (CntW+1)'(emit_byte_c);
    asm_wide_c   = {ByteW'(0), asm_q};
    word_le_c    = '0;
    strb_le_c    = '0;
    // Lanes beyond the current fill are forced to zero so stale assembly bytes never leak.
    for (int k = 0; k < NumLanes; k++) begin
      if ((CntW+1)'(k) < {1'b0, cnt_q}) begin
        word_le_c[ByteW*k +: ByteW] = asm_wide_c[ByteW*k +: ByteW];
      end else if (accept_c && (CntW'(k) == cnt_q)) begin
        word_le_c[ByteW*k +: ByteW] = in_data_i;
      end
      strb_le_c[k] = (CntW+1)'(k) < nbytes_c;
    end
  end

  // Byte order and strobe mirroring selected by the endianness parameter.
  always_comb begin
    word_out_c = word_le_c;
    strb_out_c = strb_le_c;
    if (BigEndian) begin
      for (int k = 0; k < NumLanes; k++) begin
        word_out_c[ByteW*k +: ByteW] = word_le_c[ByteW*(NumLanes-1-k) +: ByteW];
        strb_out_c[k]                = strb_le_c[NumLanes-1-k];
      end
    end
  end

  // Next-state for the assembly counter and register.
  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (load_c) begin
      cnt_d = '0;
    end else if (accept_c) begin
      cnt_d = cnt_q + CntW'(1);
      for (int k = 0; k < NumLanes - 1; k++) begin
        if (CntW'(k) == cnt_q) begin
          asm_d[ByteW*k +: ByteW] = in_data_i;
        end
      end
    end
  end

  // Next-state for the output register; a new load wins over a drain.
  always_comb begin
    data_d  = data_q;
    strb_d  = strb_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_c) begin
      data_d  = word_out_c;
      strb_d  = strb_out_c;
      last_d  = emit_byte_c && in_last_i;
      valid_d = 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_strb_o  = strb_q;
  assign out_last_o  = last_q;
  assign out_valid_o = valid_q;
  assign fill_o      = cnt_q;

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: little- and big-endian instances share stimulus; words are
// checked against a scoreboard queue, plus fill/valid per cycle, stalls and reset.
module tb_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        le_in_ready, be_in_ready;
  logic [31:0] le_data, be_data;
  logic [3:0]  le_strb, be_strb;
  logic        le_last, be_last, le_valid, be_valid;
  logic [1:0]  le_fill, be_fill;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } exp_t;

  exp_t q_le[$];
  exp_t q_be[$];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        f;
    logic [1:0]  fill;
    logic        ov;
    logic [31:0] le;
    logic [3:0]  ls;
    logic [31:0] be;
    logic [3:0]  bs;
    logic        last;
  } vec_t;

  vec_t vt[21];

  word_packer #(.BigEndian(1'b0)) u_le (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_last_i(in_last),
    .in_valid_i(in_valid), .in_ready_o(le_in_ready), .flush_i(flush),
    .out_data_o(le_data), .out_strb_o(le_strb), .out_last_o(le_last),
    .out_valid_o(le_valid), .out_ready_i(out_ready), .fill_o(le_fill)
  );

  word_packer #(.BigEndian(1'b1)) u_be (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_last_i(in_last),
    .in_valid_i(in_valid), .in_ready_o(be_in_ready), .flush_i(flush),
    .out_data_o(be_data), .out_strb_o(be_strb), .out_last_o(be_last),
    .out_valid_o(be_valid), .out_ready_i(out_ready), .fill_o(be_fill)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  logic        stall_prev = 1'b0;
  logic [36:0] held_prev = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (le_valid && out_ready) begin
        if (q_le.size() == 0) chk("le_unexpected_word", 64'(le_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("le_word", 64'({le_data, le_strb, le_last}), 64'(q_le.pop_front()));
      end
      if (be_valid && out_ready) begin
        if (q_be.size() == 0) chk("be_unexpected_word", 64'(be_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("be_word", 64'({be_data, be_strb, be_last}), 64'(q_be.pop_front()));
      end
      chk("in_ready", 64'(le_in_ready), 64'(!le_valid || out_ready));
      if (stall_prev) chk("stall_hold", 64'({le_valid, le_data, le_strb, le_last}), 64'({1'b1, held_prev}));
      stall_prev = le_valid && !out_ready;
      held_prev  = {le_data, le_strb, le_last};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_word(input logic [31:0] le, input logic [3:0] ls,
                           input logic [31:0] be, input logic [3:0] bs, input logic l);
    exp_t e;
    e = '{d: le, s: ls, l: l};
    q_le.push_back(e);
    e = '{d: be, s: bs, l: l};
    q_be.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1; in_data = d; in_last = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [7:0] sb[16];
  int i, cyc;
  logic acc;
  int j;

  initial begin
    //          v     d      l     f     fill  ov    le            ls     be            bs     last
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 2'd0, 1'b1, 32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[6]  = '{1'b1, 8'hBB, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000BBAA, 4'h3, 32'hAABB0000, 4'hC, 1'b1};
    vt[7]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[8]  = '{1'b1, 8'hDD, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000DDCC, 4'h3, 32'hCCDD0000, 4'hC, 1'b1};
    vt[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[11] = '{1'b1, 8'h03, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 32'h00030201, 4'h7, 32'h01020300, 4'hE, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[17] = '{1'b1, 8'h55, 1'b0, 1'b1, 2'd0, 1'b1, 32'h00000055, 4'h1, 32'h55000000, 4'h8, 1'b0};
    vt[18] = '{1'b1, 8'h66, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        4'h0, 1'b0};
    vt[19] = '{1'b1, 8'h77, 1'b1, 1'b1, 2'd0, 1'b1, 32'h00007766, 4'h3, 32'h66770000, 4'hC, 1'b1};
    vt[20] = '{1'b1, 8'h88, 1'b1, 1'b0, 2'd0, 1'b1, 32'h00000088, 4'h1, 32'h88000000, 4'h8, 1'b1};

    // Reset values, observed asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(le_valid), 64'd0);
    chk("rst_data", 64'(le_data), 64'd0);
    chk("rst_strb", 64'(le_strb), 64'd0);
    chk("rst_last", 64'(le_last), 64'd0);
    chk("rst_fill", 64'(le_fill), 64'd0);
    chk("rst_in_ready", 64'(le_in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table with out_ready held high.
    out_ready = 1'b1;
    for (int k = 0; k < 21; k++) begin
      in_valid = vt[k].v; in_data = vt[k].d; in_last = vt[k].l; flush = vt[k].f;
      if (vt[k].ov) push_word(vt[k].le, vt[k].ls, vt[k].be, vt[k].bs, vt[k].last);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_fill", k), 64'(le_fill), 64'(vt[k].fill));
      chk($sformatf("vec%0d_be_fill", k), 64'(be_fill), 64'(vt[k].fill));
      chk($sformatf("vec%0d_valid", k), 64'(le_valid), 64'(vt[k].ov));
    end
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("table_drained", 64'(q_le.size() + q_be.size()), 64'd0);

    // 16-byte stream with random backpressure.
    for (int k = 0; k < 16; k++) sb[k] = 8'($urandom_range(0, 255));
    i = 0; cyc = 0;
    while (i < 16 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1; in_data = sb[i]; in_last = 1'b0; flush = 1'b0;
      #1;
      acc = le_in_ready;
      if (acc && (i % 4 == 3)) begin
        j = i - 3;
        push_word({sb[j+3], sb[j+2], sb[j+1], sb[j]}, 4'hF,
                  {sb[j], sb[j+1], sb[j+2], sb[j+3]}, 4'hF, 1'b0);
      end
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    chk("stream_bytes_accepted", 64'(i), 64'd16);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((q_le.size() != 0 || q_be.size() != 0) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_words_drained", 64'(q_le.size() + q_be.size()), 64'd0);
    chk("stream_fill", 64'(le_fill), 64'd0);

    // Reset with two bytes in assembly.
    out_ready = 1'b0;
    send_byte(8'hE1);
    send_byte(8'hE2);
    chk("pre_rst_fill", 64'(le_fill), 64'd2);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_fill", 64'(le_fill), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset with a word held under backpressure; that word must never appear.
    send_byte(8'hF1); send_byte(8'hF2); send_byte(8'hF3); send_byte(8'hF4);
    chk("held_valid", 64'(le_valid), 64'd1);
    chk("held_in_ready", 64'(le_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("held_rst_valid", 64'(le_valid), 64'd0);
    chk("held_rst_fill", 64'(le_fill), 64'd0);
    chk("held_rst_data", 64'(le_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Packing restarts from lane 0.
    out_ready = 1'b1;
    send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C);
    push_word(32'h8D7C6B5A, 4'hF, 32'h5A6B7C8D, 4'hF, 1'b0);
    send_byte(8'h8D);
    chk("post_rst_valid", 64'(le_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", 64'(q_le.size() + q_be.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_packer.md
# word_packer

Upstream stage of the data-word FIFO. It packs an 8-bit byte stream into 32-bit data words (`word_t`) with a per-byte strobe and a last flag, and presents them through a valid/ready interface that writes directly into the FIFO. It holds one partially assembled word plus one output register. With `out_ready_i` high it sustains one byte per cycle.

## Interface
Parameters:
- `BigEndian`, default 0: 0 places the first byte in `[7:0]`; 1 places the first byte in `[31:24]`.

Ports:
- `clk_i` input, 1 bit: clock. All state updates on the rising edge.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `in_data_i` input, 8 bits: byte payload.
- `in_last_i` input, 1 bit: byte ends a packet.
- `in_valid_i` input, 1 bit: byte valid.
- `in_ready_o` output, 1 bit: packer accepts a byte or flush this cycle.
- `flush_i` input, 1 bit: emit the partial word now.
- `out_data_o` output, 32 bits (`word_t`): packed word.
- `out_strb_o` output, 4 bits: valid-byte mask. Bit k covers byte lane k in little-endian order; the mask is mirrored when `BigEndian` = 1.
- `out_last_o` output, 1 bit: word ends a packet.
- `out_valid_o` output, 1 bit: word valid.
- `out_ready_i` input, 1 bit: the FIFO accepts the word.
- `fill_o` output, 2 bits: number of bytes currently held in assembly (0–3).

## Operation
State and ready:
- State consists of the 2-bit byte counter `cnt`, a 24-bit assembly register, and the output register (`data`, `strb`, `last`, `valid`).
- `in_ready_o` = `!out_valid_o || out_ready_i`. It is combinational and stalls only when a held word is not being taken.

Byte accept (`in_valid_i && in_ready_o`):
- Write the byte into lane `cnt` of the assembly.
- If `cnt` == 3 or `in_last_i` = 1: load the output register and set `cnt` to 0.
  - `data` = assembled bytes plus this byte. Unused lanes are 0.
  - `strb` = the lower `cnt+1` bits set.
  - `last` = `in_last_i`.
  - `valid` = 1.
- Otherwise: `cnt` increments.

Flush (`flush_i && in_ready_o`):
- With no byte accepted and `cnt` > 0: emit the partial word with `strb` = the lower `cnt` bits set and `last` = 0. `cnt` goes to 0.
- With `cnt` == 0 and no byte: ignored. No empty word is ever produced.
- With a byte accepted the same cycle: the byte is included and the word is emitted immediately (`cnt+1` bytes), with `last` = `in_last_i`.
- `flush_i` is not stored. Upstream holds it until `in_ready_o` is high.

Output register:
- If `out_valid_o && out_ready_i` and no new word loads, `valid` clears.
- Load and drain in the same cycle: the new word replaces the old one and `valid` stays 1.
- `out_*` signals are stable while `out_valid_o && !out_ready_i`.

General:
- `fill_o` = `cnt`.
- `out_strb_o` is always a contiguous run of ones starting at lane 0 and is never 0 when valid.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream) sets:
  - `cnt` = 0, `fill_o` = 0;
  - `out_valid_o` = 0, `out_data_o` = 0, `out_strb_o` = 0, `out_last_o` = 0;
  - `in_ready_o` = 1 (derived).
- Reset mid-packet discards the assembly and any held word without emitting them.
- Latency: the 4th byte (or the last byte) accepted at edge N gives `out_valid_o` = 1 after edge N.
- Throughput: 4 bytes per 4 cycles, continuous, with `out_ready_i` = 1.
- Backpressure: `in_ready_o` falls in the same cycle `out_ready_i` falls while a word is held. No byte is lost or duplicated.
- `in_valid_i` low between bytes keeps `cnt` unchanged indefinitely.

## Test plan
- Reset, then bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready_i` = 1 → one word 0x44332211, strb 0xF, last 0, valid exactly 1 cycle after the 4th byte; `fill_o` goes 1, 2, 3, 0.
- `BigEndian` = 1 with the same bytes → 0x11223344, strb 0xF.
- Bytes 0xAA, 0xBB(last) → 0x0000BBAA, strb 0x3, last 1; the next byte lands in lane 0.
- Three bytes 0x01, 0x02, 0x03, idle, then `flush_i` → 0x00030201, strb 0x7, last 0; a flush with `fill_o` = 0 produces no word.
- Continuous 16-byte stream with `out_ready_i` randomly deasserted → exactly 4 words, in order, bit-exact; `in_ready_o` low precisely when valid && !ready; outputs stable while stalled.
- Assert `rst_ni` low after 2 bytes with a word held → `out_valid_o` and `fill_o` are 0 immediately (asynchronous); the following 4-byte sequence packs from lane 0.
